// File: rtl/bcd_subtractor_seq.sv
// Digit-serial N-digit BCD subtractor: D = X - Y in 10's-complement BCD,
// one digit per clock, least-significant digit first, start/busy/done handshake.
// Digit k of every operand occupies bits [4k+3:4k].
// Optional feature: define BCD_SUB_INVALID_DETECT_EN to add the err output,
// which flags operands containing a digit greater than 9.
module bcd_subtractor_seq #(
    parameter int unsigned N = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [4*N-1:0] X,
    input  logic [4*N-1:0] Y,
    output logic           busy,
    output logic           done,
    output logic [4*N-1:0] D,
`ifdef BCD_SUB_INVALID_DETECT_EN
    output logic           err,
`endif
    output logic           b_out
);

    localparam int unsigned W    = 4 * N;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LAST = N - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    d_q, d_d;
    logic            b_out_q, b_out_d;
`ifdef BCD_SUB_INVALID_DETECT_EN
    logic            flag_q, flag_d;
    logic            err_q, err_d;
`endif

    // Per-digit working values for the digit selected by the counter
    logic [3:0]      xk, yk, dig;
    logic [4:0]      t;
    logic [CW+1:0]   shamt;

    // Next-state, datapath and output computation
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        d_d      = d_q;
        b_out_d  = b_out_q;
`ifdef BCD_SUB_INVALID_DETECT_EN
        flag_d   = flag_q;
        err_d    = err_q;
`endif
        shamt    = {cnt_q, 2'b00};
        xk       = 4'(x_q >> shamt);
        yk       = 4'(y_q >> shamt);
        t        = 5'({1'b0, xk}) - 5'({1'b0, yk}) - 5'(borrow_q);
        dig      = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d      = X;
                    y_d      = Y;
                    work_d   = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    busy_d   = 1'b1;
`ifdef BCD_SUB_INVALID_DETECT_EN
                    flag_d   = 1'b0;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                // A negative 5-bit result wraps back into 0..9 by adding ten
                if (t[4]) begin
                    dig      = 4'(t + 5'd10);
                    borrow_d = 1'b1;
                end else begin
                    dig      = t[3:0];
                    borrow_d = 1'b0;
                end
                work_d = (work_q & ~(W'(4'hF) << shamt)) | (W'(dig) << shamt);
                cnt_d  = cnt_q + CW'(1);
`ifdef BCD_SUB_INVALID_DETECT_EN
                flag_d = flag_q | (xk > 4'd9) | (yk > 4'd9);
`endif
                if (cnt_q == CW'(LAST)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    d_d     = work_d;
                    b_out_d = borrow_d;
`ifdef BCD_SUB_INVALID_DETECT_EN
                    err_d   = flag_d;
                    if (flag_d) begin
                        d_d     = '0;
                        b_out_d = 1'b0;
                    end
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            b_out_q  <= 1'b0;
`ifdef BCD_SUB_INVALID_DETECT_EN
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            d_q      <= d_d;
            b_out_q  <= b_out_d;
`ifdef BCD_SUB_INVALID_DETECT_EN
            flag_q   <= flag_d;
            err_q    <= err_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign D     = d_q;
    assign b_out = b_out_q;
`ifdef BCD_SUB_INVALID_DETECT_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq (N=2): arithmetic, handshake,
// back-to-back issue, mid-operation reset and, when BCD_SUB_INVALID_DETECT_EN
// is defined, the invalid-digit flag.
module tb_bcd_subtractor_seq;

    localparam int unsigned N = 2;
    localparam int unsigned W = 4 * N;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] X, Y, D;
    logic         busy, done, b_out;
`ifdef BCD_SUB_INVALID_DETECT_EN
    logic         err;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   lat;
    int   done_before;

    always #5 clk = ~clk;

    bcd_subtractor_seq #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .X       (X),
        .Y       (Y),
        .busy    (busy),
        .done    (done),
        .D       (D),
`ifdef BCD_SUB_INVALID_DETECT_EN
        .err     (err),
`endif
        .b_out   (b_out)
    );

    // Single comparison point: counts and reports every check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal subtraction on integers, wrapped to 10^N on borrow
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       r;
        int         xi = 0;
        int         yi = 0;
        int         p  = 1;
        int         di;
        bit         inv = 1'b0;
        logic [3:0] dx, dy;
        for (int k = 0; k < int'(N); k++) begin
            dx  = 4'(x >> (4 * k));
            dy  = 4'(y >> (4 * k));
            inv = inv | (dx > 4'd9) | (dy > 4'd9);
            xi += int'(dx) * p;
            yi += int'(dy) * p;
            p  *= 10;
        end
        di  = xi - yi;
        r.b = (di < 0);
        if (di < 0) di += p;
        r.d = '0;
        for (int k = 0; k < int'(N); k++) begin
            r.d = r.d | (W'(di % 10) << (4 * k));
            di  = di / 10;
        end
        r.e = 1'b0;
`ifdef BCD_SUB_INVALID_DETECT_EN
        if (inv) begin
            r.d = '0;
            r.b = 1'b0;
            r.e = 1'b1;
        end
`endif
        return r;
    endfunction

    // Scoreboard: every done pops the oldest expected result
    always @(negedge clk) begin
        if (reset_n && done) begin
            n_done++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("D", 32'(D), 32'(mon_e.d));
                check("b_out", 32'(b_out), 32'(mon_e.b));
`ifdef BCD_SUB_INVALID_DETECT_EN
                check("err", 32'(err), 32'(mon_e.e));
`endif
            end
        end
    end

    // Drive one start pulse from a negedge; returns just after the accepting edge
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        X     = x;
        Y     = y;
        start = 1'b1;
        if (push) sb.push_back(model(x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Bounded wait for done; busy must stay high until done appears
    task automatic wait_done(output int l);
        l = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                l = i;
                check("busy_at_done", 32'(busy), 32'd0);
                break;
            end
            check("busy_running", 32'(busy), 32'd1);
        end
        check("done_seen", 32'(l >= 0), 32'd1);
    endtask

    logic [W-1:0] ops_x [5] = '{8'h45, 8'h03, 8'h00, 8'h50, 8'h77};
    logic [W-1:0] ops_y [5] = '{8'h23, 8'h05, 8'h99, 8'h01, 8'h77};

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        X       = '0;
        Y       = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D", 32'(D), 32'h00);
        check("rst_b_out", 32'(b_out), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases, including borrow ripple and X == Y
        for (int i = 0; i < 5; i++) begin
            launch(ops_x[i], ops_y[i], 1'b1);
            wait_done(lat);
            check("latency", 32'(lat), 32'(N));
            @(negedge clk);
        end

        // start re-asserted during RUN with changed operands is ignored
        done_before = n_done;
        launch(8'h45, 8'h23, 1'b1);
        @(negedge clk);
        X     = 8'h99;
        Y     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check("latency_ignored_start", 32'(lat), 32'(N - 1));
        repeat (N + 2) @(negedge clk);
        check("one_done", 32'(n_done - done_before), 32'd1);

        // Back-to-back: new start issued in the done cycle
        launch(8'h45, 8'h23, 1'b1);
        wait_done(lat);
        check("latency_b2b_first", 32'(lat), 32'(N));
        launch(8'h10, 8'h02, 1'b1);
        wait_done(lat);
        check("latency_b2b_second", 32'(lat), 32'(N));
        @(negedge clk);
        check("D_hold_before_reset", 32'(D), 32'h08);

        // Reset mid-RUN aborts the operation without a done
        launch(8'h31, 8'h12, 1'b0);
        @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_D", 32'(D), 32'h00);
        check("abort_b_out", 32'(b_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        done_before = n_done;
        repeat (N + 3) @(negedge clk);
        check("no_done_after_abort", 32'(n_done - done_before), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);
        launch(8'h31, 8'h12, 1'b1);
        wait_done(lat);
        check("latency_after_abort", 32'(lat), 32'(N));
        @(negedge clk);

`ifdef BCD_SUB_INVALID_DETECT_EN
        // Invalid digit forces a zero result with err, next valid op clears it
        launch(8'h4A, 8'h01, 1'b1);
        wait_done(lat);
        check("latency_invalid", 32'(lat), 32'(N));
        @(negedge clk);
        check("err_held", 32'(err), 32'd1);
        launch(8'h12, 8'h01, 1'b1);
        wait_done(lat);
        check("latency_after_invalid", 32'(lat), 32'(N));
        @(negedge clk);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
